// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// default widths and the alignment rule used by both store and load paths.
package mem_stage_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_ADDR_DEF = 6;

  // 2'b11 is decoded as a word access as well.
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return offset[0];
      default:    return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and the debug read port of the MEM stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) ();

  logic               i_step;
  logic               i_mem2reg;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data4Mem;
  logic [NB_REG-1:0]  i_write_reg;
  logic [NB_ADDR-1:0] i_debug_addr;

  logic               o_mem2reg;
  logic               o_regWrite;
  logic [NB_REG-1:0]  o_write_reg;
  logic [NB_DATA-1:0] o_read_data;
  logic [NB_DATA-1:0] o_result;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_debug_data;

  modport master (
    output i_step, i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_result, i_data4Mem, i_write_reg, i_debug_addr,
    input  o_mem2reg, o_regWrite, o_write_reg, o_read_data, o_result,
           o_misaligned, o_debug_data
  );

  modport slave (
    input  i_step, i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_result, i_data4Mem, i_write_reg, i_debug_addr,
    output o_mem2reg, o_regWrite, o_write_reg, o_read_data, o_result,
           o_misaligned, o_debug_data
  );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory with per-byte-lane write enables, cleared by
// reset, with one combinational access read port and one debug read port.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  input  logic [NB_DATA/8-1:0] i_lane_mask,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic [NB_DATA-1:0]   o_rdata,
  input  logic [NB_ADDR-1:0]   i_debug_addr,
  output logic [NB_DATA-1:0]   o_debug_data
);

  localparam int DEPTH   = 2 ** NB_ADDR;
  localparam int NB_LANE = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < NB_LANE; b++)
        if (i_lane_mask[b]) mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata      = mem[i_addr];
  assign o_debug_data = mem[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-lane decode for stores, load extraction and extension,
// and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input logic        clk,
  input logic        i_reset,
  mem_stage_if.slave bus
);

  localparam int NB_LANE = NB_DATA / 8;

  logic [1:0]         offset;
  logic [NB_ADDR-1:0] word_idx;
  logic               misaligned;
  logic               slot_misaligned;
  logic               we;
  logic [NB_LANE-1:0] lane_mask;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] rdata;
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [NB_DATA-1:0] load_data;
  logic               unused_addr_bits;

  assign offset           = bus.i_result[1:0];
  assign word_idx         = bus.i_result[NB_ADDR+1:2];
  assign unused_addr_bits = ^bus.i_result[NB_DATA-1:NB_ADDR+2];
  assign misaligned       = is_misaligned(bus.i_width, offset);
  // Only real memory operations report misalignment and squash the register write.
  assign slot_misaligned  = misaligned & (bus.i_mem2reg | bus.i_memWrite);
  assign we               = bus.i_step & bus.i_memWrite & ~misaligned;

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    lane_mask = '1;
    wdata     = bus.i_data4Mem;
    case (bus.i_width)
      WIDTH_BYTE: begin
        lane_mask = NB_LANE'(1) << offset;
        wdata     = {NB_LANE{bus.i_data4Mem[7:0]}};
      end
      WIDTH_HALF: begin
        lane_mask = NB_LANE'(3) << offset;
        wdata     = {(NB_LANE/2){bus.i_data4Mem[15:0]}};
      end
      default: ;
    endcase
  end

  data_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_data_memory (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_we         (we),
    .i_lane_mask  (lane_mask),
    .i_addr       (word_idx),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .i_debug_addr (bus.i_debug_addr),
    .o_debug_data (bus.o_debug_data)
  );

  assign lane_byte = rdata[{offset, 3'b000} +: 8];
  assign lane_half = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (!misaligned) begin
      case (bus.i_width)
        WIDTH_BYTE: load_data = {{(NB_DATA-8){bus.i_sign_flag & lane_byte[7]}}, lane_byte};
        WIDTH_HALF: load_data = {{(NB_DATA-16){bus.i_sign_flag & lane_half[15]}}, lane_half};
        default:    load_data = rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      bus.o_mem2reg    <= 1'b0;
      bus.o_regWrite   <= 1'b0;
      bus.o_write_reg  <= '0;
      bus.o_read_data  <= '0;
      bus.o_result     <= '0;
      bus.o_misaligned <= 1'b0;
    end else if (bus.i_step) begin
      bus.o_mem2reg    <= bus.i_mem2reg;
      bus.o_regWrite   <= bus.i_regWrite & ~slot_misaligned;
      bus.o_write_reg  <= bus.i_write_reg;
      bus.o_read_data  <= load_data;
      bus.o_result     <= bus.i_result;
      bus.o_misaligned <= slot_misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic checked against a byte-array model of the data memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic i_reset;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0]  mem_b [256];
  logic        exp_m2r, exp_rw, exp_mis;
  logic [4:0]  exp_wr;
  logic [31:0] exp_rd, exp_res;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {mem_b[4*w+3], mem_b[4*w+2], mem_b[4*w+1], mem_b[4*w]};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ":mem2reg"},    32'(bus.o_mem2reg),    32'(exp_m2r));
    chk({tag, ":regWrite"},   32'(bus.o_regWrite),   32'(exp_rw));
    chk({tag, ":write_reg"},  32'(bus.o_write_reg),  32'(exp_wr));
    chk({tag, ":read_data"},  bus.o_read_data,       exp_rd);
    chk({tag, ":result"},     bus.o_result,          exp_res);
    chk({tag, ":misaligned"}, 32'(bus.o_misaligned), 32'(exp_mis));
    chk({tag, ":debug"},      bus.o_debug_data,      model_word(int'(bus.i_debug_addr)));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    exp_m2r = 0; exp_rw = 0; exp_mis = 0; exp_wr = '0; exp_rd = '0; exp_res = '0;
  endtask

  // One pipeline slot: predict from the spec rules, apply, clock, compare.
  task automatic cycle(input string tag, input logic step, input logic m2r, input logic mw,
                       input logic rw, input logic [1:0] w, input logic sgn,
                       input logic [31:0] res, input logic [31:0] data, input logic [4:0] wr);
    int a, size;
    logic mis;
    logic [31:0] val;
    bus.i_step = step; bus.i_mem2reg = m2r; bus.i_memWrite = mw; bus.i_regWrite = rw;
    bus.i_width = w; bus.i_sign_flag = sgn; bus.i_result = res; bus.i_data4Mem = data;
    bus.i_write_reg = wr;
    bus.i_debug_addr = 6'($urandom_range(0, 63));
    a    = int'(res[7:0]);
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    mis  = (a % size) != 0;
    if (step) begin
      val = 0;
      if (!mis) begin
        for (int k = 0; k < size; k++) val = val + (32'(mem_b[a+k]) << (8*k));
        if (size < 4 && sgn && val[8*size-1]) val = val - (32'd1 << (8*size));
      end
      exp_m2r = m2r;
      exp_mis = mis && (m2r || mw);
      exp_rw  = rw && !exp_mis;
      exp_wr  = wr;
      exp_res = res;
      exp_rd  = val;
      if (mw && !mis)
        for (int k = 0; k < size; k++) mem_b[a+k] = 8'(data >> (8*k));
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_debug(input string tag, input int w, input logic [31:0] exp);
    bus.i_debug_addr = 6'(w);
    #1;
    chk(tag, bus.o_debug_data, exp);
  endtask

  // Drop reset right now (between edges) and verify everything reads zero.
  task automatic reset_and_check(input string tag);
    i_reset = 1'b0;
    #1;
    clear_model();
    check_outputs(tag);
    for (int w = 0; w < 64; w++) begin
      bus.i_debug_addr = 6'(w);
      #1;
      chk({tag, ":debug_clear"}, bus.o_debug_data, 32'h0);
    end
  endtask

  initial begin
    i_reset = 1'b0;
    bus.i_step = 0; bus.i_mem2reg = 0; bus.i_memWrite = 0; bus.i_regWrite = 0;
    bus.i_width = 0; bus.i_sign_flag = 0; bus.i_result = 0; bus.i_data4Mem = 0;
    bus.i_write_reg = 0; bus.i_debug_addr = 0;
    clear_model();
    #12;
    check_outputs("reset");
    @(negedge clk);
    i_reset = 1'b1;

    cycle("st_word", 1, 0, 1, 0, WIDTH_WORD, 0, 32'h08, 32'hDEADBEEF, 5'd0);
    check_debug("tp_debug_w2", 2, 32'hDEADBEEF);
    cycle("ld_word", 1, 1, 0, 1, WIDTH_WORD, 0, 32'h08, 32'h0, 5'd3);
    chk("tp_word_load", bus.o_read_data, 32'hDEADBEEF);
    cycle("ld_sbyte", 1, 1, 0, 1, WIDTH_BYTE, 1, 32'h0B, 32'h0, 5'd4);
    chk("tp_sbyte", bus.o_read_data, 32'hFFFFFFDE);
    cycle("ld_ubyte", 1, 1, 0, 1, WIDTH_BYTE, 0, 32'h0B, 32'h0, 5'd5);
    chk("tp_ubyte", bus.o_read_data, 32'h000000DE);
    cycle("ld_shalf", 1, 1, 0, 1, WIDTH_HALF, 1, 32'h08, 32'h0, 5'd6);
    chk("tp_shalf", bus.o_read_data, 32'hFFFFBEEF);
    cycle("st_byte", 1, 0, 1, 0, WIDTH_BYTE, 0, 32'h09, 32'hCAFE5512, 5'd0);
    check_debug("tp_byte_merge", 2, 32'hDEAD12EF);
    cycle("st_mis", 1, 0, 1, 1, WIDTH_WORD, 0, 32'h0A, 32'h11223344, 5'd9);
    chk("tp_mis_flag", 32'(bus.o_misaligned), 32'd1);
    chk("tp_mis_regwrite", 32'(bus.o_regWrite), 32'd0);
    check_debug("tp_mis_nowrite", 2, 32'hDEAD12EF);
    cycle("wrap_load", 1, 1, 0, 1, WIDTH_WORD, 0, 32'hFFFF_FF08, 32'h0, 5'd10);

    for (int i = 0; i < 3; i++)
      cycle("stall", 0, 0, 1, 1, WIDTH_WORD, 0, 32'h10, 32'hAAAA5555, 5'd7);
    check_debug("tp_stall_nowrite", 4, 32'h0);
    cycle("unstall", 1, 0, 1, 1, WIDTH_WORD, 0, 32'h10, 32'hAAAA5555, 5'd7);
    check_debug("tp_unstall_write", 4, 32'hAAAA5555);
    cycle("stall_after", 0, 0, 1, 1, WIDTH_WORD, 0, 32'h10, 32'h12345678, 5'd8);
    check_debug("tp_single_write", 4, 32'hAAAA5555);

    bus.i_step = 1; bus.i_memWrite = 1; bus.i_width = WIDTH_WORD;
    bus.i_result = 32'h14; bus.i_data4Mem = 32'h12345678;
    #2;
    reset_and_check("reset_mid_store");
    @(negedge clk);
    i_reset = 1'b1;
    cycle("after_abort", 1, 1, 0, 1, WIDTH_WORD, 0, 32'h14, 32'h0, 5'd1);
    chk("tp_aborted_store", bus.o_read_data, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      r[7:6] = 2'b00;
      cycle("random", $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), r, $urandom, 5'($urandom));
    end

    @(posedge clk);
    #2;
    reset_and_check("async_reset");
    @(negedge clk);
    i_reset = 1'b1;
    cycle("post_reset", 1, 1, 0, 1, WIDTH_WORD, 0, 32'h08, 32'h0, 5'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
